// File: rtl/bitonic_loader.sv
// bitonic_loader
//   Input framing stage for the bitonic sorter. Collects a serial stream of
//   signed words (valid/ready) into an N-element frame. A frame closes on the
//   N-th element or on in_last, whichever comes first. Unused slots are filled
//   with the sort-neutral extreme so padding always sorts to the tail. The
//   frame is then held on the parallel output until the network accepts it.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     upstream element valid
//   in_ready     loader can accept an element (high while filling)
//   in_data      signed element, WIDTH bits
//   in_last      final element of the current frame (qualified by in_valid)
//   frame_valid  frame_data / frame_count valid (high while emitting)
//   frame_ready  sorting network accepts the frame this cycle
//   frame_data   slot k at bits [k*WIDTH +: WIDTH], k = 0 first received
//   frame_count  number of real (non-pad) elements, 1..N
module bitonic_loader #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int DIR   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [N*WIDTH-1:0]   frame_data,
  output logic [$clog2(N):0]   frame_count
);

  localparam int IW = $clog2(N);

  // Ascending network: pad with the most-positive value so pads end up last.
  // Descending network: pad with the most-negative value for the same reason.
  localparam logic [WIDTH-1:0] PAD = (DIR != 0) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                : {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW:0]   CNT_ONE  = (IW + 1)'(1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [N*WIDTH-1:0]   r_frame;
  logic [IW:0]          r_count;

  logic                 w_accept;
  logic                 w_close;
  logic                 w_release;
  logic [N-1:0]         w_sel;
  logic [N-1:0]         w_above;

  assign w_accept  = (r_state == S_FILL) && in_valid;
  assign w_close   = in_last || (r_idx == LAST_IDX);
  assign w_release = (r_state == S_EMIT) && frame_ready;

  // Per-slot decode: w_sel marks the slot written by this element, w_above
  // marks the slots that get padded when the frame closes early.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot_dec
      localparam logic [IW-1:0] SLOT = IW'(gi);
      assign w_sel[gi]   = (r_idx == SLOT);
      assign w_above[gi] = (SLOT > r_idx);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_frame <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        for (int j = 0; j < N; j++) begin
          if (w_sel[j]) begin
            r_frame[j*WIDTH +: WIDTH] <= in_data;
          end else if (w_close && w_above[j]) begin
            r_frame[j*WIDTH +: WIDTH] <= PAD;
          end
        end
        if (w_close) begin
          r_count <= {1'b0, r_idx} + CNT_ONE;
          r_idx   <= '0;
          r_state <= S_EMIT;
        end else begin
          r_idx   <= r_idx + IDX_ONE;
        end
      end
      if (w_release) begin
        r_state <= S_FILL;
      end
    end
  end

  // Handshake outputs decode straight from the state register, so there is
  // no combinational path from any input to any output.
  assign in_ready    = (r_state == S_FILL);
  assign frame_valid = (r_state == S_EMIT);
  assign frame_data  = r_frame;
  assign frame_count = r_count;

endmodule

// File: tb/tb_bitonic_loader.sv
// Testbench for bitonic_loader. Two instances share one input stream: one
// configured ascending (DIR=1), one descending (DIR=0), so every frame checks
// both pad values. A queue-based reference model predicts the frames.
module tb_bitonic_loader;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int CW = 4;
  localparam logic [W-1:0] PAD_A = 32'h7FFF_FFFF;
  localparam logic [W-1:0] PAD_D = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            frame_ready = 1'b0;
  logic [W-1:0]    in_data = '0;

  logic            a_ready, a_valid, d_ready, d_valid;
  logic [N*W-1:0]  a_data, d_data;
  logic [CW-1:0]   a_count, d_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0]    m_buf[$];
  bit              m_emit = 1'b0;
  int              m_count = 0;
  logic [N*W-1:0]  m_frame_a = '0;
  logic [N*W-1:0]  m_frame_d = '0;

  always #5 clk = ~clk;

  bitonic_loader #(.WIDTH(W), .N(N), .DIR(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_ready), .in_data(in_data), .in_last(in_last),
    .frame_valid(a_valid), .frame_ready(frame_ready),
    .frame_data(a_data), .frame_count(a_count)
  );

  bitonic_loader #(.WIDTH(W), .N(N), .DIR(0)) dut_d (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(d_ready), .in_data(in_data), .in_last(in_last),
    .frame_valid(d_valid), .frame_ready(frame_ready),
    .frame_data(d_data), .frame_count(d_count)
  );

  function automatic logic [N*W-1:0] model_pack(input logic [W-1:0] pad);
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) begin
      f[k*W +: W] = (k < m_buf.size()) ? m_buf[k] : pad;
    end
    return f;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_emit = 1'b0;
    m_count = 0;
  endtask

  // Advance the model with the inputs currently driven, then move to 1 time
  // unit after the next rising edge where outputs are sampled.
  task automatic tick();
    if (m_emit) begin
      if (frame_ready) m_emit = 1'b0;
    end else if (in_valid) begin
      m_buf.push_back(in_data);
      if (in_last || m_buf.size() == N) begin
        m_count   = m_buf.size();
        m_frame_a = model_pack(PAD_A);
        m_frame_d = model_pack(PAD_D);
        m_buf.delete();
        m_emit    = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
      errors++; $display("FAIL reset_hs got=%b exp=0101", {a_valid, a_ready, d_valid, d_ready});
    end
    checks++;
    if (a_data !== '0 || a_count !== '0) begin
      errors++; $display("FAIL reset_a got=%h/%0d exp=0/0", a_data, a_count);
    end
    checks++;
    if (d_data !== '0 || d_count !== '0) begin
      errors++; $display("FAIL reset_d got=%h/%0d exp=0/0", d_data, d_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    int el[8] = '{5, -3, 7, 0, 2, -8, 1, 4};
    logic [N*W-1:0] exp_f;
    frame_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_data = W'(el[k]);
      exp_f[k*W +: W] = W'(el[k]);
      checks++;
      if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
        errors++; $display("FAIL full_fill_hs k=%0d got=%b exp=0101", k, {a_valid, a_ready, d_valid, d_ready});
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b1010) begin
      errors++; $display("FAIL full_emit_hs got=%b exp=1010", {a_valid, a_ready, d_valid, d_ready});
    end
    checks++;
    if (a_data !== exp_f || a_count !== 4'd8) begin
      errors++; $display("FAIL full_frame_a got=%h/%0d exp=%h/8", a_data, a_count, exp_f);
    end
    checks++;
    if (d_data !== exp_f || d_count !== 4'd8) begin
      errors++; $display("FAIL full_frame_d got=%h/%0d exp=%h/8", d_data, d_count, exp_f);
    end
    tick();
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
      errors++; $display("FAIL full_release got=%b exp=0101", {a_valid, a_ready, d_valid, d_ready});
    end
    $display("test_full_frame done");
  endtask

  task automatic test_short_frame();
    int el[3] = '{9, -1, 3};
    logic [N*W-1:0] exp_a, exp_d;
    frame_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_a[k*W +: W] = (k < 3) ? W'(el[k]) : PAD_A;
      exp_d[k*W +: W] = (k < 3) ? W'(el[k]) : PAD_D;
    end
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = W'(el[k]);
      in_last = (k == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b1010) begin
      errors++; $display("FAIL short_emit_hs got=%b exp=1010", {a_valid, a_ready, d_valid, d_ready});
    end
    checks++;
    if (a_data !== exp_a || a_count !== 4'd3) begin
      errors++; $display("FAIL short_frame_a got=%h/%0d exp=%h/3", a_data, a_count, exp_a);
    end
    checks++;
    if (d_data !== exp_d || d_count !== 4'd3) begin
      errors++; $display("FAIL short_frame_d got=%h/%0d exp=%h/3", d_data, d_count, exp_d);
    end
    frame_ready = 1'b1;
    tick();
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
      errors++; $display("FAIL short_release got=%b exp=0101", {a_valid, a_ready, d_valid, d_ready});
    end
    $display("test_short_frame done");
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] exp_f, exp_a2, exp_d2;
    logic [W-1:0] e0, e1;
    // frame_ready low during fill must have no effect
    frame_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_data = $urandom;
      exp_f[k*W +: W] = in_data;
      tick();
    end
    // upstream keeps offering junk while the frame is held
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({a_valid, a_ready, d_valid, d_ready} !== 4'b1010) begin
        errors++; $display("FAIL bp_hold_hs c=%0d got=%b exp=1010", c, {a_valid, a_ready, d_valid, d_ready});
      end
      checks++;
      if (a_data !== exp_f || a_count !== 4'd8 || d_data !== exp_f || d_count !== 4'd8) begin
        errors++; $display("FAIL bp_hold_data c=%0d got=%h/%0d exp=%h/8", c, a_data, a_count, exp_f);
      end
      in_data = $urandom;
      if (c < 5) tick();
    end
    frame_ready = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
      errors++; $display("FAIL bp_release got=%b exp=0101", {a_valid, a_ready, d_valid, d_ready});
    end
    // next frame must contain only the two new elements
    e0 = $urandom; e1 = $urandom;
    for (int k = 0; k < N; k++) begin
      exp_a2[k*W +: W] = (k == 0) ? e0 : (k == 1) ? e1 : PAD_A;
      exp_d2[k*W +: W] = (k == 0) ? e0 : (k == 1) ? e1 : PAD_D;
    end
    frame_ready = 1'b0;
    in_valid = 1'b1; in_data = e0; in_last = 1'b0;
    tick();
    in_data = e1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== exp_a2 || a_count !== 4'd2) begin
      errors++; $display("FAIL bp_next_a got=%b/%h/%0d exp=1/%h/2", a_valid, a_data, a_count, exp_a2);
    end
    checks++;
    if (d_valid !== 1'b1 || d_data !== exp_d2 || d_count !== 4'd2) begin
      errors++; $display("FAIL bp_next_d got=%b/%h/%0d exp=1/%h/2", d_valid, d_data, d_count, exp_d2);
    end
    frame_ready = 1'b1;
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_single();
    logic [N*W-1:0] exp_a, exp_d;
    logic [W-1:0] v;
    v = W'(-42);
    for (int k = 0; k < N; k++) begin
      exp_a[k*W +: W] = (k == 0) ? v : PAD_A;
      exp_d[k*W +: W] = (k == 0) ? v : PAD_D;
    end
    frame_ready = 1'b0;
    in_valid = 1'b1; in_data = v; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== exp_a || a_count !== 4'd1) begin
      errors++; $display("FAIL single_a got=%b/%h/%0d exp=1/%h/1", a_valid, a_data, a_count, exp_a);
    end
    checks++;
    if (d_valid !== 1'b1 || d_data !== exp_d || d_count !== 4'd1) begin
      errors++; $display("FAIL single_d got=%b/%h/%0d exp=1/%h/1", d_valid, d_data, d_count, exp_d);
    end
    frame_ready = 1'b1;
    tick();
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
      errors++; $display("FAIL single_release got=%b exp=0101", {a_valid, a_ready, d_valid, d_ready});
    end
    $display("test_single done");
  endtask

  task automatic test_reset_mid_fill();
    logic [N*W-1:0] exp_f;
    frame_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({a_valid, a_ready, d_valid, d_ready} !== 4'b0101) begin
      errors++; $display("FAIL rst_mid_hs got=%b exp=0101", {a_valid, a_ready, d_valid, d_ready});
    end
    checks++;
    if (a_data !== '0 || a_count !== '0 || d_data !== '0 || d_count !== '0) begin
      errors++; $display("FAIL rst_mid_clear got=%h/%0d exp=0/0", a_data, a_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_data = $urandom;
      exp_f[k*W +: W] = in_data;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== exp_f || a_count !== 4'd8) begin
      errors++; $display("FAIL rst_mid_next_a got=%b/%h/%0d exp=1/%h/8", a_valid, a_data, a_count, exp_f);
    end
    checks++;
    if (d_valid !== 1'b1 || d_data !== exp_f || d_count !== 4'd8) begin
      errors++; $display("FAIL rst_mid_next_d got=%b/%h/%0d exp=1/%h/8", d_valid, d_data, d_count, exp_f);
    end
    tick();
    $display("test_reset_mid_fill done");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] el[24];
    logic [N*W-1:0] exp_f;
    int p = 0;
    int frames = 0;
    bit exp_v;
    for (int k = 0; k < 24; k++) el[k] = $urandom;
    frame_ready = 1'b1; in_last = 1'b0;
    // frames are emitted after edges 8, 17, 26; the edge after each is the
    // one EMIT cycle where nothing is accepted
    for (int c = 1; c <= 27; c++) begin
      in_valid = (p < 24);
      in_data  = (p < 24) ? el[p] : '0;
      tick();
      if ((c % 9) != 0 && p < 24) p++;
      exp_v = ((c % 9) == 8);
      checks++;
      if ({a_valid, a_ready, d_valid, d_ready} !== {exp_v, !exp_v, exp_v, !exp_v}) begin
        errors++; $display("FAIL b2b_hs c=%0d got=%b exp=%b", c, {a_valid, a_ready, d_valid, d_ready}, {exp_v, !exp_v, exp_v, !exp_v});
      end
      if (exp_v) begin
        for (int k = 0; k < N; k++) exp_f[k*W +: W] = el[frames*N + k];
        checks++;
        if (a_data !== exp_f || a_count !== 4'd8 || d_data !== exp_f || d_count !== 4'd8) begin
          errors++; $display("FAIL b2b_frame f=%0d got=%h/%0d exp=%h/8", frames, a_data, a_count, exp_f);
        end
        frames++;
      end
    end
    in_valid = 1'b0;
    $display("test_back_to_back done frames=%0d", frames);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = $urandom;
      in_last     = ($urandom_range(0, 4) == 0);
      frame_ready = $urandom_range(0, 1);
      tick();
      checks++;
      if ({a_valid, a_ready, d_valid, d_ready} !== {m_emit, !m_emit, m_emit, !m_emit}) begin
        errors++; $display("FAIL rand_hs c=%0d got=%b exp=%b", c, {a_valid, a_ready, d_valid, d_ready}, {m_emit, !m_emit, m_emit, !m_emit});
      end
      if (m_emit) begin
        checks++;
        if (a_data !== m_frame_a || a_count !== CW'(m_count)) begin
          errors++; $display("FAIL rand_frame_a c=%0d got=%h/%0d exp=%h/%0d", c, a_data, a_count, m_frame_a, m_count);
        end
        checks++;
        if (d_data !== m_frame_d || d_count !== CW'(m_count)) begin
          errors++; $display("FAIL rand_frame_d c=%0d got=%h/%0d exp=%h/%0d", c, d_data, d_count, m_frame_d, m_count);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_single();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitonic_loader.md
# bitonic_loader

Input framing stage for the bitonic sorter. It collects a serial stream of signed words over a valid/ready handshake into an N-element frame and pads short frames with a sentinel so the sort order is preserved. It then presents the whole frame in parallel to the first compare-swap column of the sorting network, holding it until the network accepts it.

## Interface

Parameters:
- WIDTH, 32, bits per signed element.
- N, 8, elements per frame; power of two, N >= 2.
- DIR, 1, sort direction of the downstream network. 1 = ascending, pad = most-positive value (0x7FFF_FFFF at WIDTH=32). 0 = descending, pad = most-negative value (0x8000_0000).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, in_data/in_last valid this cycle.
- in_ready, output, 1, loader can accept an element this cycle.
- in_data, input, WIDTH, signed element.
- in_last, input, 1, final element of the current frame; meaningful only with in_valid.
- frame_valid, output, 1, frame_data/frame_count valid.
- frame_ready, input, 1, sorting network accepts the frame this cycle.
- frame_data, output, N*WIDTH, slot k (k-th element received, k=0 first) at bits [k*WIDTH +: WIDTH].
- frame_count, output, $clog2(N)+1, number of real (non-pad) elements, 1..N.

## Operation

- Two states: FILL and EMIT. Reset state is FILL.
- Internal slot index idx is $clog2(N) bits and resets to 0.
- FILL:
  - in_ready = 1 and frame_valid = 0.
  - An element is accepted on a clock edge where in_valid & in_ready.
  - On acceptance, slot[idx] <= in_data.
  - If idx == N-1 or in_last is set on acceptance:
    - every slot j > idx <= pad value (same edge);
    - frame_count <= idx+1;
    - idx <= 0;
    - go to EMIT.
  - Otherwise idx <= idx+1.
- EMIT:
  - in_ready = 0 and frame_valid = 1.
  - frame_data and frame_count are held stable.
  - On an edge with frame_ready = 1, go to FILL.
  - frame_ready is ignored in FILL.
- Widths:
  - Data is passed through unmodified; no arithmetic is applied to elements.
  - Pad value is the signed extreme of WIDTH bits selected by DIR.
- Boundary cases:
  - in_last on the N-th element: identical to a full frame, no padding, frame_count = N.
  - in_last on the first element: slots 1..N-1 are padded, frame_count = 1.
  - in_last with in_valid = 0 is ignored.
  - in_valid held high during EMIT: nothing is accepted and the upstream must hold its data (in_ready = 0).
  - Slots not yet written during FILL hold stale contents. They are don't-care while frame_valid = 0.
- Reset asserted at any time (mid-fill or mid-emit):
  - the partial or pending frame is discarded;
  - state = FILL, idx = 0;
  - all slots = 0, frame_count = 0, frame_valid = 0.

## Timing

- Reset values:
  - frame_valid = 0, frame_data = 0, frame_count = 0.
  - in_ready = 1 (FILL). The first element can be accepted on the first rising edge after rst deasserts.
- Latency: frame_valid rises in the cycle after the edge that accepted the last element of the frame.
- frame_valid stays high until the first edge with frame_ready = 1. frame_valid = 0 and in_ready = 1 in the following cycle.
- Throughput: with in_valid and frame_ready held high, one frame of N elements every N+1 cycles. This includes one EMIT cycle with in_ready = 0.
- frame_ready may be high before frame_valid. The transfer then completes on the first EMIT edge, giving a one-cycle frame_valid pulse.
- All outputs are registered or decoded directly from state; there is no combinational path from in_* to frame_* or from frame_ready to in_ready.

## Test plan

- Full frame, defaults (WIDTH=32, N=8, DIR=1): stream 5,-3,7,0,2,-8,1,4 with in_valid continuous and frame_ready=1.
  - Expected: frame_valid high for 1 cycle, exactly 1 cycle after the 8th accept.
  - Expected: slots = 5,-3,7,0,2,-8,1,4 and frame_count = 8.
- Short frame: stream 9,-1,3 with in_last on 3.
  - Expected: slots 3..7 = 0x7FFF_FFFF and frame_count = 3.
  - Repeat with DIR=0: slots 3..7 = 0x8000_0000.
- Backpressure: hold frame_ready=0 for 5 cycles after frame_valid rises.
  - Expected: frame_valid, frame_data and frame_count stable and in_ready=0 throughout.
  - Expected: after frame_ready=1, one transfer and in_ready=1 on the next cycle.
- Single-element frame: one word -42 with in_last.
  - Expected: slot0 = -42, slots 1..7 = pad, frame_count = 1.
- Reset mid-fill: accept 4 elements, then assert rst asynchronously (between edges) for 2 cycles.
  - Expected: outputs 0 and in_ready=1 immediately on assertion.
  - Expected: the next 8 elements form a clean frame with no carry-over of the 4 earlier elements.
- Back-to-back frames: 24 elements, in_valid continuous, frame_ready=1.
  - Expected: 3 frames in 27 cycles, in order.
  - Expected: no element dropped or duplicated; each frame has frame_count=8.
